ds18b20_slave: RTL and testbench
================================

Name: ds18b20_slave

Overview:
- Behavioural-synthesizable DS18B20 responder: the device end of the one-wire bus that ds18b20_drive masters.
- Sits on the board-level one_wire net in loopback/test builds, so the temperature path can run without the physical sensor.
- Temperature comes from a fabric input (e.g. switch bank or test register) instead of a sensor die.
- Supports reset/presence, Skip ROM (0xCC), Convert T (0x44) and Read Scratchpad (0xBE) with Dallas CRC8.

Parameters:
- CLK_MHZ, 50, system clock in MHz; sets the 1 us tick divider.
- RST_US, 400, minimum line-low time recognised as a master reset pulse.
- PRES_WAIT_US, 30, delay from reset release to presence pulse start.
- PRES_US, 120, presence pulse low duration.
- SAMPLE_US, 30, write-slot sample point after the falling edge.
- TX_LOW_US, 45, hold-low time when sending a 0 in a read slot.
- CONV_US, 750000, conversion busy time; the bench overrides it to 200.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- one_wire  inout  1  open-drain bus; driven 1'b0 or 1'bz only, never 1.
- temp_in  input  16  two's-complement 1/16 degC value captured at the end of a conversion.
- conv_pulse  output  1  one-cycle strobe when a 0x44 command byte completes.
- scratch_temp  output  16  current scratchpad temperature.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (rst=0):
  - one_wire=z, conv_pulse=0, busy=0, scratch_temp=16'h0550 (85 degC power-up value).
  - FSM goes to IDLE; the us counter and bit counter clear.
- Input handling: one_wire is passed through a 2-FF synchroniser. A falling edge is a high-to-low change of the synchronised value, and is ignored while the slave itself drives low.
- Timing base: us_tick is a 1-cycle pulse every CLK_MHZ clocks. All durations below are counted in us_tick units.
- Reset detection (any state): the line-low counter runs whenever the synchronised line is 0.
  - Reaching RST_US sets rst_seen.
  - The rising edge with rst_seen set forces PRES_WAIT and aborts any transfer.
  - A conversion in progress continues.
- States:
  - IDLE: wait for reset.
  - PRES_WAIT: PRES_WAIT_US, then PRES_DRIVE.
  - PRES_DRIVE: drive low for PRES_US, release, then ROM_RX.
  - ROM_RX: receive 8 bits. 0xCC goes to FUNC_RX; any other value goes to HALT.
  - FUNC_RX: receive 8 bits.
    - 0x44: conv_pulse, busy=1, then STAT_TX.
    - 0xBE: load the TX shifter with byte 0, then SCR_TX.
    - Other values: HALT.
  - STAT_TX: each read slot returns busy?0:1.
  - SCR_TX: transmit the 9-byte scratchpad, LSB first.
    - Bytes 0-8: temp[7:0], temp[15:8], 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, CRC.
    - CRC is Dallas CRC8 (x^8+x^5+x^4+1, reflected, init 0) over bytes 0-7.
    - After byte 8, read slots return 1 (bus released).
  - HALT: release the bus and ignore slots until a reset.
- Write slot (RX states): a falling edge starts the slot counter. At SAMPLE_US the synchronised line is shifted in LSB first. The byte completes on the 8th sample.
- Read slot (TX states): on a falling edge with tx bit=0, drive low for TX_LOW_US from the edge; with tx bit=1, never drive. The bit shifts on slot end, which is TX_LOW_US after the edge.
- Conversion: busy counts CONV_US. At terminal count, scratch_temp<=temp_in and busy<=0, in the same cycle.
  - A 0x44 received while busy restarts the count.
  - A Read Scratchpad issued during a conversion sends the old scratch_temp.
- Boundary cases:
  - A slot edge arriving while still driving low is ignored.
  - A low of length between the slot sample point and RST_US is a normal slot. The sample is taken at SAMPLE_US only.
  - rst deasserted mid-slot: the slave starts in IDLE and does not drive until a full reset/presence sequence.

Test Plan:
- Power-up, then master reset low 480 us and release -> slave pulls low 30 us after release for 120 us (±1 us); one_wire is z otherwise.
- Reset, 0xCC, 0xBE, 72 read slots with no prior convert -> bytes 50 05 4B 46 7F FF 0C 10 1C; CRC byte = 0x1C.
- temp_in=16'h0191, reset, 0xCC, 0x44, read slots -> conv_pulse one cycle; slots read 0 for 200 us then 1. Then reset, 0xCC, 0xBE -> first two bytes 91 01, CRC matches the bench model.
- Reset, then ROM byte 0x55 -> HALT; 16 read slots all read 1 and the slave never drives. A subsequent reset gives presence.
- Master reset issued mid-SCR_TX after 12 bits -> transfer aborted and presence pulse produced. A fresh 0xCC 0xBE restarts at byte 0.
- rst asserted during PRES_DRIVE -> one_wire released within 1 clock, outputs at reset values; no presence until the next master reset.

Source files
------------

// File: rtl/ds18b20_slave.sv
`default_nettype none
// ============================================================================
// Module   : ds18b20_slave
// Purpose  : DS18B20 one-wire device responder; the temperature comes from a
//            fabric input rather than a sensor die.
// Revision : 1.0  initial release
// ============================================================================
module ds18b20_slave #(
   parameter int CLK_MHZ      = 50,
   parameter int RST_US       = 400,
   parameter int PRES_WAIT_US = 30,
   parameter int PRES_US      = 120,
   parameter int SAMPLE_US    = 30,
   parameter int TX_LOW_US    = 45,
   parameter int CONV_US      = 750000
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire         one_wire,
   input  logic [15:0] temp_in,
   output logic        conv_pulse,
   output logic [15:0] scratch_temp,
   output logic        busy
);

   localparam int DIV_W   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam int T_MAX01 = (PRES_WAIT_US > PRES_US) ? PRES_WAIT_US : PRES_US;
   localparam int T_MAX23 = (SAMPLE_US > TX_LOW_US) ? SAMPLE_US : TX_LOW_US;
   localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
   localparam int TMR_W   = $clog2(T_MAX + 1);
   localparam int LOW_W   = $clog2(RST_US + 1);
   localparam int CONV_W  = $clog2(CONV_US + 1);

   localparam logic [7:0] C_CMD_SKIP = 8'hCC;
   localparam logic [7:0] C_CMD_CONV = 8'h44;
   localparam logic [7:0] C_CMD_READ = 8'hBE;

   typedef enum logic [2:0] {
      S_IDLE, S_PRES_WAIT, S_PRES_DRIVE, S_ROM_RX,
      S_FUNC_RX, S_STAT_TX, S_SCR_TX, S_HALT
   } state_t;

   function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic b);
      logic [7:0] r;
      r = {1'b0, crc[7:1]};
      if (crc[0] ^ b) r = r ^ 8'h8C;
      return r;
   endfunction

   function automatic logic [7:0] scratch_byte(input logic [3:0] idx, input logic [15:0] t);
      logic [7:0] r;
      case (idx)
         4'd0:    r = t[7:0];
         4'd1:    r = t[15:8];
         4'd2:    r = 8'h4B;
         4'd3:    r = 8'h46;
         4'd4:    r = 8'h7F;
         4'd5:    r = 8'hFF;
         4'd6:    r = 8'h0C;
         4'd7:    r = 8'h10;
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          sync_q;
   logic                prev_q;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [LOW_W-1:0]    low_q, low_d;
   logic                rst_seen_q, rst_seen_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                slot_q, slot_d;
   logic                drive_q, drive_d;
   logic [7:0]          sh_q, sh_d;
   logic [2:0]          bit_q, bit_d;
   logic [3:0]          idx_q, idx_d;
   logic [7:0]          crc_q, crc_d;
   logic [15:0]         snap_q, snap_d;
   logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
   logic                busy_q, busy_d;
   logic                pulse_q, pulse_d;
   logic [15:0]         scratch_q, scratch_d;

   logic       w_line, w_tick, w_fall, w_rise, w_txbit;
   logic [7:0] w_sh_in, w_crc_n;

   assign w_line  = sync_q[1];
   assign w_tick  = (div_q == DIV_W'(CLK_MHZ - 1));
   // Our own pull-down echoes back through the synchroniser; never treat it as a slot.
   assign w_fall  = prev_q & ~w_line & ~drive_q;
   assign w_rise  = ~prev_q & w_line;
   assign w_sh_in = {w_line, sh_q[7:1]};
   assign w_crc_n = crc_step(crc_q, sh_q[0]);
   assign w_txbit = (state_q == S_STAT_TX) ? ~busy_q :
                    ((idx_q < 4'd9) ? sh_q[0] : 1'b1);

   always_comb begin
      state_d    = state_q;
      div_d      = w_tick ? '0 : div_q + 1'b1;
      low_d      = low_q;
      rst_seen_d = rst_seen_q;
      tmr_d      = tmr_q;
      slot_d     = slot_q;
      drive_d    = drive_q;
      sh_d       = sh_q;
      bit_d      = bit_q;
      idx_d      = idx_q;
      crc_d      = crc_q;
      snap_d     = snap_q;
      conv_cnt_d = conv_cnt_q;
      busy_d     = busy_q;
      pulse_d    = 1'b0;
      scratch_d  = scratch_q;

      if (!w_line) begin
         if (w_tick && (low_q != LOW_W'(RST_US))) low_d = low_q + 1'b1;
      end else begin
         low_d = '0;
      end
      if (low_q == LOW_W'(RST_US)) rst_seen_d = 1'b1;

      if (busy_q && w_tick) begin
         if (conv_cnt_q == CONV_W'(CONV_US - 1)) begin
            busy_d     = 1'b0;
            conv_cnt_d = '0;
            scratch_d  = temp_in;
         end else begin
            conv_cnt_d = conv_cnt_q + 1'b1;
         end
      end

      if (w_rise && rst_seen_q) begin
         rst_seen_d = 1'b0;
         state_d    = S_PRES_WAIT;
         tmr_d      = '0;
         slot_d     = 1'b0;
         drive_d    = 1'b0;
         bit_d      = '0;
      end else begin
         case (state_q)
            S_PRES_WAIT: if (w_tick) begin
               if (tmr_q == TMR_W'(PRES_WAIT_US - 1)) begin
                  state_d = S_PRES_DRIVE;
                  tmr_d   = '0;
                  drive_d = 1'b1;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            S_PRES_DRIVE: if (w_tick) begin
               if (tmr_q == TMR_W'(PRES_US - 1)) begin
                  state_d = S_ROM_RX;
                  tmr_d   = '0;
                  drive_d = 1'b0;
                  bit_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            S_ROM_RX, S_FUNC_RX: begin
               if (w_fall) begin
                  slot_d = 1'b1;
                  tmr_d  = '0;
               end else if (slot_q && w_tick) begin
                  if (tmr_q == TMR_W'(SAMPLE_US - 1)) begin
                     slot_d = 1'b0;
                     sh_d   = w_sh_in;
                     bit_d  = bit_q + 3'd1;
                     if (bit_q == 3'd7) begin
                        if (state_q == S_ROM_RX) begin
                           state_d = (w_sh_in == C_CMD_SKIP) ? S_FUNC_RX : S_HALT;
                        end else if (w_sh_in == C_CMD_CONV) begin
                           pulse_d    = 1'b1;
                           busy_d     = 1'b1;
                           conv_cnt_d = '0;
                           state_d    = S_STAT_TX;
                        end else if (w_sh_in == C_CMD_READ) begin
                           // Freeze the temperature so bytes 0/1 and the CRC agree.
                           snap_d  = scratch_q;
                           sh_d    = scratch_q[7:0];
                           idx_d   = '0;
                           crc_d   = '0;
                           state_d = S_SCR_TX;
                        end else begin
                           state_d = S_HALT;
                        end
                     end
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
            end
            S_STAT_TX, S_SCR_TX: begin
               if (w_fall) begin
                  slot_d  = 1'b1;
                  tmr_d   = '0;
                  drive_d = ~w_txbit;
               end else if (slot_q && w_tick) begin
                  if (tmr_q == TMR_W'(TX_LOW_US - 1)) begin
                     slot_d  = 1'b0;
                     drive_d = 1'b0;
                     if ((state_q == S_SCR_TX) && (idx_q < 4'd9)) begin
                        if (idx_q < 4'd8) crc_d = w_crc_n;
                        sh_d  = {1'b0, sh_q[7:1]};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                           idx_d = idx_q + 4'd1;
                           sh_d  = (idx_q == 4'd7) ? w_crc_n : scratch_byte(idx_q + 4'd1, snap_q);
                        end
                     end
                  end else begin
                     tmr_d = tmr_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q     <= 2'b11;
         prev_q     <= 1'b1;
         state_q    <= S_IDLE;
         div_q      <= '0;
         low_q      <= '0;
         rst_seen_q <= 1'b0;
         tmr_q      <= '0;
         slot_q     <= 1'b0;
         drive_q    <= 1'b0;
         sh_q       <= '0;
         bit_q      <= '0;
         idx_q      <= '0;
         crc_q      <= '0;
         snap_q     <= 16'h0550;
         conv_cnt_q <= '0;
         busy_q     <= 1'b0;
         pulse_q    <= 1'b0;
         scratch_q  <= 16'h0550;
      end else begin
         sync_q     <= {sync_q[0], one_wire};
         prev_q     <= w_line;
         state_q    <= state_d;
         div_q      <= div_d;
         low_q      <= low_d;
         rst_seen_q <= rst_seen_d;
         tmr_q      <= tmr_d;
         slot_q     <= slot_d;
         drive_q    <= drive_d;
         sh_q       <= sh_d;
         bit_q      <= bit_d;
         idx_q      <= idx_d;
         crc_q      <= crc_d;
         snap_q     <= snap_d;
         conv_cnt_q <= conv_cnt_d;
         busy_q     <= busy_d;
         pulse_q    <= pulse_d;
         scratch_q  <= scratch_d;
      end
   end

   assign one_wire     = drive_q ? 1'b0 : 1'bz;
   assign conv_pulse   = pulse_q;
   assign scratch_temp = scratch_q;
   assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ds18b20_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds18b20_slave
// Purpose  : One-wire master model and scoreboard for ds18b20_slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_ds18b20_slave;

   localparam int CLK_MHZ  = 2;
   localparam int CONV_US  = 200;
   localparam int US       = 1000;
   localparam int CYC      = US / CLK_MHZ;
   localparam int HALF     = CYC / 2;
   // Slave edge detection runs a few clocks behind the bus at this slow clock.
   localparam int PRES_LO  = 29 * US;
   localparam int PRES_HI  = 33 * US;
   // Remaining time in the 0x44 write slot after the slave samples its last bit.
   localparam int CONV_OFS = 35;

   logic        clk, rst, m_drive;
   logic [15:0] temp_in;
   wire         one_wire;
   logic        conv_pulse, busy;
   logic [15:0] scratch_temp;

   assign one_wire = m_drive ? 1'b0 : 1'bz;
   pullup (one_wire);

   ds18b20_slave #(.CLK_MHZ(CLK_MHZ), .CONV_US(CONV_US)) dut (
      .clk(clk), .rst(rst), .one_wire(one_wire), .temp_in(temp_in),
      .conv_pulse(conv_pulse), .scratch_temp(scratch_temp), .busy(busy)
   );

   int          checks = 0;
   int          failures = 0;
   logic        chk_on = 1'b0, chk_silent = 1'b1, chk_scr = 1'b0, chk_busy = 1'b0;
   logic        pulse_ok = 1'b0, exp_busy = 1'b0;
   logic [15:0] exp_scr = 16'h0550;
   int          pulse_cnt = 0;
   logic [7:0]  exp_b [9];
   logic [7:0]  got_b [9];

   initial begin
      clk = 1'b0;
      forever #(HALF) clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   // Scratchpad image and Dallas CRC8 straight from the byte definitions.
   task automatic build_model(input logic [15:0] t);
      logic [7:0] c;
      logic       fb;
      exp_b[0] = t[7:0];  exp_b[1] = t[15:8]; exp_b[2] = 8'h4B; exp_b[3] = 8'h46;
      exp_b[4] = 8'h7F;   exp_b[5] = 8'hFF;   exp_b[6] = 8'h0C; exp_b[7] = 8'h10;
      c = 8'h00;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ exp_b[k][j];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
         end
      end
      exp_b[8] = c;
   endtask

   task automatic write_bit(input logic b);
      m_drive = 1'b1;
      if (b) begin
         #(5 * US);  m_drive = 1'b0; #(60 * US);
      end else begin
         #(60 * US); m_drive = 1'b0; #(5 * US);
      end
   endtask

   task automatic write_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) write_bit(v[i]);
   endtask

   task automatic read_bit(output logic b);
      m_drive = 1'b1;
      #(2 * US);
      m_drive = 1'b0;
      #(12 * US);
      b = one_wire;
      #(51 * US);
   endtask

   task automatic read_byte(output logic [7:0] v);
      logic b;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         v[i] = b;
      end
   endtask

   task automatic read_scratch(input string tag, input int n);
      logic [7:0] v;
      chk_silent = 1'b0;
      for (int k = 0; k < n; k++) begin
         read_byte(v);
         got_b[k] = v;
         chk($sformatf("%s byte%0d", tag, k), {24'h0, v}, {24'h0, exp_b[k]});
      end
      chk_silent = 1'b1;
   endtask

   task automatic master_reset(input string tag);
      int first, last;
      chk_silent = 1'b0;
      m_drive = 1'b1;
      #(480 * US);
      m_drive = 1'b0;
      first = -1;
      last  = -1;
      for (int i = 1; i <= 340; i++) begin
         @(negedge clk);
         if (one_wire === 1'b0) begin
            if (first < 0) first = i;
            last = i;
         end
      end
      chk_range({tag, " pres_start"}, first * CYC, PRES_LO, PRES_HI);
      chk_range({tag, " pres_len"}, (last - first + 1) * CYC, 119 * US, 121 * US);
      chk_silent = 1'b1;
   endtask

   always @(posedge clk) begin
      #(HALF / 2);
      if (chk_on) begin
         if (chk_scr)  chk("scratch_temp", {16'h0, scratch_temp}, {16'h0, exp_scr});
         if (chk_busy) chk("busy", {31'h0, busy}, {31'h0, exp_busy});
         if (!pulse_ok) chk("conv_pulse_idle", {31'h0, conv_pulse}, 32'h0);
         else if (conv_pulse) pulse_cnt++;
         if (chk_silent && !m_drive) chk("bus_released", {31'h0, one_wire}, 32'h1);
      end
   end

   initial begin
      #(60000 * US);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       b;
      logic [7:0] v;
      rst = 1'b0; m_drive = 1'b0; temp_in = 16'h0000;
      repeat (4) @(negedge clk);
      chk("rst conv_pulse", {31'h0, conv_pulse}, 32'h0);
      chk("rst busy", {31'h0, busy}, 32'h0);
      chk("rst scratch", {16'h0, scratch_temp}, 32'h0550);
      chk("rst bus", {31'h0, one_wire}, 32'h1);
      rst = 1'b1;
      exp_scr = 16'h0550; chk_scr = 1'b1; exp_busy = 1'b0; chk_busy = 1'b1; chk_on = 1'b1;
      repeat (2) @(negedge clk);

      // Power-up presence, then default scratchpad.
      master_reset("t1");
      write_byte(8'hCC);
      write_byte(8'hBE);
      build_model(16'h0550);
      read_scratch("t2", 9);
      chk("t2 crc literal", {24'h0, got_b[8]}, 32'h1C);

      // Convert T, status polling, then read back the new temperature.
      temp_in = 16'h0191;
      master_reset("t3a");
      write_byte(8'hCC);
      pulse_cnt = 0; pulse_ok = 1'b1; chk_busy = 1'b0; chk_scr = 1'b0;
      write_byte(8'h44);
      chk("t3 conv_pulse_cycles", pulse_cnt, 1);
      chk("t3 busy_after_44", {31'h0, busy}, 32'h1);
      chk_silent = 1'b0;
      for (int k = 0; k < 6; k++) begin
         read_bit(b);
         chk($sformatf("t3 status%0d", k), {31'h0, b},
             ((CONV_OFS + 65 * k) < CONV_US) ? 32'h0 : 32'h1);
      end
      chk_silent = 1'b1; pulse_ok = 1'b0;
      chk("t3 scratch_after_conv", {16'h0, scratch_temp}, 32'h0191);
      exp_scr = 16'h0191; chk_scr = 1'b1; exp_busy = 1'b0; chk_busy = 1'b1;
      master_reset("t3b");
      write_byte(8'hCC);
      write_byte(8'hBE);
      build_model(16'h0191);
      read_scratch("t3b", 9);
      chk("t3 byte0 literal", {24'h0, got_b[0]}, 32'h91);
      chk("t3 byte1 literal", {24'h0, got_b[1]}, 32'h01);

      // Unsupported ROM command: bus must stay released.
      master_reset("t4a");
      write_byte(8'h55);
      for (int k = 0; k < 2; k++) begin
         read_byte(v);
         chk($sformatf("t4 halt byte%0d", k), {24'h0, v}, 32'hFF);
      end
      master_reset("t4b");

      // Abort mid-scratchpad, then restart from byte 0.
      write_byte(8'hCC);
      write_byte(8'hBE);
      read_scratch("t5 partial", 1);
      chk_silent = 1'b0;
      for (int k = 0; k < 4; k++) read_bit(b);
      master_reset("t5");
      write_byte(8'hCC);
      write_byte(8'hBE);
      read_scratch("t5 restart", 2);

      // Device reset while presence is being driven.
      chk_silent = 1'b0;
      m_drive = 1'b1;
      #(480 * US);
      m_drive = 1'b0;
      #(60 * US);
      chk("t6 presence_active", {31'h0, one_wire}, 32'h0);
      chk_scr = 1'b0; exp_scr = 16'h0550;
      rst = 1'b0;
      #1;
      chk("t6 bus_on_rst", {31'h0, one_wire}, 32'h1);
      chk("t6 busy_on_rst", {31'h0, busy}, 32'h0);
      chk("t6 pulse_on_rst", {31'h0, conv_pulse}, 32'h0);
      chk("t6 scratch_on_rst", {16'h0, scratch_temp}, 32'h0550);
      chk_scr = 1'b1; chk_silent = 1'b1;
      @(negedge clk);
      #(5 * US);
      rst = 1'b1;
      #(200 * US);
      master_reset("t6b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
